// File: rtl/ip_tx_hdr_insert_pipe.sv
// ip_tx_hdr_insert_pipe: checksums a 20-byte IPv4 header and prepends it to a payload stream,
// realigning payload bytes so header and payload leave as one contiguous MSB-first stream.
module ip_tx_hdr_insert_pipe #(
  parameter int DATA_WIDTH = 512,
  parameter int DATA_BYTES = DATA_WIDTH/8,
  parameter int PADBYTES_WIDTH = $clog2(DATA_BYTES),
  parameter int IP_HDR_BYTES = 20
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      src_ip_format_tx_hdr_val,
  input  logic [IP_HDR_BYTES*8-1:0] src_ip_format_tx_hdr,
  output logic                      ip_format_src_tx_hdr_rdy,
  input  logic                      src_ip_format_tx_data_val,
  input  logic [DATA_WIDTH-1:0]     src_ip_format_tx_data,
  input  logic                      src_ip_format_tx_last,
  input  logic [PADBYTES_WIDTH-1:0] src_ip_format_tx_padbytes,
  output logic                      ip_format_src_tx_data_rdy,
  output logic                      ip_format_dst_tx_val,
  output logic [DATA_WIDTH-1:0]     ip_format_dst_tx_data,
  output logic                      ip_format_dst_tx_last,
  output logic [PADBYTES_WIDTH-1:0] ip_format_dst_tx_padbytes,
  input  logic                      dst_ip_format_tx_rdy
);
  localparam int HW = IP_HDR_BYTES*8;
  localparam int BW = DATA_WIDTH - HW;
  localparam logic [PADBYTES_WIDTH-1:0] HB = PADBYTES_WIDTH'(IP_HDR_BYTES);
  localparam logic [PADBYTES_WIDTH-1:0] DP = PADBYTES_WIDTH'(DATA_BYTES - IP_HDR_BYTES);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SUM   = 3'd1;
  localparam logic [2:0] S_FOLD  = 3'd2;
  localparam logic [2:0] S_FIRST = 3'd3;
  localparam logic [2:0] S_BODY  = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;

  logic [2:0]                r_state;
  logic [2:0]                w_next;
  logic [HW-1:0]             r_hdr;
  logic [HW-1:0]             r_carry;
  logic [19:0]               r_sum;
  logic                      r_hdr_only;
  logic [PADBYTES_WIDTH-1:0] r_drain_pad;
  logic [19:0]               w_sum;
  logic [16:0]               w_fold;
  logic [15:0]               w_ck;
  logic                      w_stream;
  logic                      w_tail;
  logic                      w_fire;
  logic                      w_big;
  logic [2:0]                w_after;
  logic [HW-1:0]             w_lead;
  logic [DATA_WIDTH-1:0]     w_raw;
  logic [DATA_WIDTH-1:0]     w_mask;
  logic [PADBYTES_WIDTH-1:0] w_pad_raw;
  logic [PADBYTES_WIDTH:0]   w_keep;

  // checksum word (index 5) is excluded from the sum
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < 10; i++)
      if (i != 5) w_sum = w_sum + 20'(r_hdr[HW-1-16*i -: 16]);
  end

  assign w_fold = {1'b0, r_sum[15:0]} + 17'(r_sum[19:16]);
  assign w_ck   = ~(w_fold[15:0] + 16'(w_fold[16]));

  assign w_stream = (r_state == S_FIRST && !r_hdr_only) || r_state == S_BODY;
  assign w_tail   = (r_state == S_FIRST && r_hdr_only) || r_state == S_DRAIN;
  assign w_fire   = w_stream && src_ip_format_tx_data_val && dst_ip_format_tx_rdy;
  assign w_big    = src_ip_format_tx_padbytes >= HB;
  assign w_after  = !src_ip_format_tx_last ? S_BODY : w_big ? S_IDLE : S_DRAIN;
  assign w_lead   = r_state == S_FIRST ? r_hdr : r_carry;

  assign ip_format_src_tx_hdr_rdy  = r_state == S_IDLE;
  assign ip_format_src_tx_data_rdy = w_stream && dst_ip_format_tx_rdy;
  assign ip_format_dst_tx_val      = w_stream ? src_ip_format_tx_data_val : w_tail;
  assign ip_format_dst_tx_last     = w_stream ? (src_ip_format_tx_last && w_big) : w_tail;

  assign w_pad_raw = w_stream ? src_ip_format_tx_padbytes - HB :
                     r_state == S_DRAIN ? r_drain_pad : DP;
  assign ip_format_dst_tx_padbytes = ip_format_dst_tx_last ? w_pad_raw : '0;

  // only the leading (DATA_BYTES - padbytes) bytes survive; the rest are forced to zero
  assign w_keep = (PADBYTES_WIDTH+1)'(DATA_BYTES) - {1'b0, ip_format_dst_tx_padbytes};
  assign w_mask = ~({DATA_WIDTH{1'b1}} >> {w_keep, 3'b000});
  assign w_raw  = w_tail ? {w_lead, {BW{1'b0}}} : {w_lead, src_ip_format_tx_data[DATA_WIDTH-1 -: BW]};
  assign ip_format_dst_tx_data = w_raw & w_mask;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = src_ip_format_tx_hdr_val ? S_SUM : S_IDLE;
      S_SUM:   w_next = S_FOLD;
      S_FOLD:  w_next = S_FIRST;
      S_FIRST: w_next = r_hdr_only ? (dst_ip_format_tx_rdy ? S_IDLE : S_FIRST) : (w_fire ? w_after : S_FIRST);
      S_BODY:  w_next = w_fire ? w_after : S_BODY;
      S_DRAIN: w_next = dst_ip_format_tx_rdy ? S_IDLE : S_DRAIN;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;

  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && src_ip_format_tx_hdr_val) r_hdr <= src_ip_format_tx_hdr;
    if (r_state == S_SUM) r_sum <= w_sum;
    if (r_state == S_FOLD) begin
      r_hdr[79:64] <= w_ck;
      r_hdr_only   <= r_hdr[143:128] == 16'(IP_HDR_BYTES);
    end
    if (w_fire) begin
      r_carry     <= src_ip_format_tx_data[HW-1:0];
      r_drain_pad <= DP + src_ip_format_tx_padbytes;
    end
  end
endmodule

// File: tb/tb_ip_tx_hdr_insert_pipe.sv
// tb_ip_tx_hdr_insert_pipe: directed vector table plus randomized packets checked against a
// byte-stream model (checksummed header + payload, cut into zero-filled lines).
module tb_ip_tx_hdr_insert_pipe;
  localparam int DW = 512;
  localparam int DB = 64;
  localparam int PW = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hv = 1'b0;
  logic [159:0] hd = '0;
  logic hrdy;
  logic dv = 1'b0;
  logic [DW-1:0] dd = '0;
  logic dl = 1'b0;
  logic [PW-1:0] dp = '0;
  logic drdy;
  logic ov;
  logic [DW-1:0] od;
  logic ol;
  logic [PW-1:0] op;
  logic orr = 1'b1;
  int rdy_mode = 0;

  always #5 clk = ~clk;

  ip_tx_hdr_insert_pipe dut (
    .clk(clk), .rst(rst),
    .src_ip_format_tx_hdr_val(hv), .src_ip_format_tx_hdr(hd), .ip_format_src_tx_hdr_rdy(hrdy),
    .src_ip_format_tx_data_val(dv), .src_ip_format_tx_data(dd), .src_ip_format_tx_last(dl),
    .src_ip_format_tx_padbytes(dp), .ip_format_src_tx_data_rdy(drdy),
    .ip_format_dst_tx_val(ov), .ip_format_dst_tx_data(od), .ip_format_dst_tx_last(ol),
    .ip_format_dst_tx_padbytes(op), .dst_ip_format_tx_rdy(orr)
  );

  int n_cmp = 0, n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] pay_q[$];
  int len_q[$];
  int rem = 0, lines_total = 0, pkts_done = 0, pkt_lines = 0;
  int hs_cnt = 0, rdy_cnt = 0, stall_obs = 0;
  logic [15:0] pkt_ck = '0;
  logic [PW-1:0] last_pad = '0;
  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_d = '0;
  logic [PW+1:0] prev_c = '0;

  function automatic void chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // reference checksum: ones-complement sum with end-around carry folded until none remains
  function automatic logic [15:0] csum(logic [159:0] h);
    int s = 0;
    for (int i = 0; i < 10; i++) if (i != 5) s += int'(h[159-16*i -: 16]);
    while (s > 65535) s = (s & 65535) + (s >> 16);
    return ~(16'(s));
  endfunction

  function automatic logic [159:0] mkhdr(int tl, logic [7:0] vi);
    return {vi, 8'($urandom), 16'(tl), 16'($urandom), 16'($urandom), 16'($urandom),
            16'($urandom), 32'($urandom), 32'($urandom)};
  endfunction

  function automatic void add_pkt(logic [159:0] h);
    logic [159:0] hh = h;
    int plen = int'(h[143:128]) - 20;
    hh[79:64] = csum(h);
    for (int b = 0; b < 20; b++) exp_q.push_back(hh[159-8*b -: 8]);
    for (int b = 0; b < plen; b++) begin
      logic [7:0] x = 8'($urandom);
      pay_q.push_back(x);
      exp_q.push_back(x);
    end
    len_q.push_back(20 + plen);
  endfunction

  function automatic logic [DW-1:0] pop_line(int n);
    logic [DW-1:0] d;
    for (int b = 0; b < DB; b++) d[DW-1-8*b -: 8] = b < n ? pay_q.pop_front() : 8'($urandom);
    return d;
  endfunction

  function automatic void check_line();
    logic [DW-1:0] e = '0;
    int n;
    bit first = 0;
    if (rem == 0) begin
      if (len_q.size() == 0) begin
        chk("unexpected_line", DW'(ov), '0);
        return;
      end
      rem = len_q.pop_front();
      first = 1;
      pkt_lines = 0;
    end
    n = rem < DB ? rem : DB;
    for (int b = 0; b < n; b++) e[DW-1-8*b -: 8] = exp_q.size() > 0 ? exp_q.pop_front() : 8'h00;
    rem -= n;
    chk("line_data", od, e);
    chk("line_last", DW'(ol), DW'(rem == 0));
    if (rem == 0) chk("line_pad", DW'(op), DW'(DB - n));
    if (first) pkt_ck = od[DW-81 -: 16];
    pkt_lines++;
    lines_total++;
    if (rem == 0) begin
      last_pad = op;
      pkts_done++;
    end
  endfunction

  initial forever begin
    @(negedge clk);
    if (rst) begin
      prev_stall = 1'b0;
      while (rem > 0) begin
        void'(exp_q.pop_front());
        rem--;
      end
    end else begin
      if (prev_stall) begin
        chk("hold_data", od, prev_d);
        chk("hold_ctl", DW'({ov, ol, op}), DW'(prev_c));
      end
      prev_stall = ov && !orr;
      prev_d = od;
      prev_c = {ov, ol, op};
      if (ov && !orr) begin
        stall_obs++;
        chk("stall_data_rdy", DW'(drdy), '0);
      end
      if (drdy) rdy_cnt++;
      if (dv && drdy) hs_cnt++;
      if (ov && orr) check_line();
    end
  end

  initial forever begin
    @(posedge clk);
    #2;
    orr = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ($urandom % 4 != 0) : 1'b0;
  end

  task automatic send_hdr(input logic [159:0] h);
    bit ok = 0;
    hv = 1'b1;
    hd = h;
    for (int k = 0; k < 3000 && !ok; k++) begin
      @(negedge clk);
      ok = hrdy;
    end
    if (!ok) chk("hdr_timeout", DW'(hrdy), DW'(1));
    @(posedge clk);
    #1;
    hv = 1'b0;
  endtask

  task automatic send_line(input logic [DW-1:0] d, input logic l, input logic [PW-1:0] p);
    bit ok = 0;
    dv = 1'b1;
    dd = d;
    dl = l;
    dp = p;
    for (int k = 0; k < 3000 && !ok; k++) begin
      @(negedge clk);
      ok = drdy;
    end
    if (!ok) chk("data_timeout", DW'(drdy), DW'(1));
    @(posedge clk);
    #1;
    dv = 1'b0;
  endtask

  task automatic send_payload(input int plen, input bit gaps);
    for (int off = 0; off < plen; off += DB) begin
      int n = plen - off < DB ? plen - off : DB;
      bit last = off + DB >= plen;
      if (gaps && $urandom % 4 == 0) begin
        @(posedge clk);
        #1;
      end
      send_line(pop_line(n), last, last ? PW'(DB - n) : PW'($urandom));
    end
  endtask

  task automatic wait_out();
    bit ok = 0;
    for (int k = 0; k < 5000 && !ok; k++) begin
      @(negedge clk);
      #1;
      ok = len_q.size() == 0 && rem == 0;
    end
    if (!ok) chk("out_timeout", DW'(len_q.size() + rem), '0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_pkt(input logic [159:0] h, input bit gaps);
    int plen = int'(h[143:128]) - 20;
    add_pkt(h);
    fork
      send_hdr(h);
      if (plen > 0) send_payload(plen, gaps);
    join
    wait_out();
  endtask

  typedef struct {
    int plen;
    logic [15:0] ck;
    int lines;
    int pad;
    int hs;
  } vec_t;

  vec_t tbl[6];
  logic [159:0] base = 160'h4500_0073_0000_4000_4011_0000_c0a8_0001_c0a8_00c7;
  logic [159:0] rh[25];
  int rl[25];

  initial begin
    logic [159:0] h;
    int hs0, r0, p0, l0, s0;
    tbl[0] = '{95, 16'hB861, 2, 13, 2};
    tbl[1] = '{0, 16'hB8C0, 1, 44, 0};
    tbl[2] = '{60, 16'hB884, 2, 48, 1};
    tbl[3] = '{44, 16'hB894, 1, 0, 1};
    tbl[4] = '{45, 16'hB893, 2, 63, 1};
    tbl[5] = '{108, 16'hB854, 2, 0, 2};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_val_in_reset", DW'(ov), '0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_val", DW'(ov), '0);
    chk("rst_data_rdy", DW'(drdy), '0);
    chk("rst_hdr_rdy", DW'(hrdy), DW'(1));
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      h = base;
      h[143:128] = 16'(20 + tbl[i].plen);
      h[79:64] = 16'hdead;
      hs0 = hs_cnt;
      r0 = rdy_cnt;
      p0 = pkts_done;
      run_pkt(h, 0);
      chk($sformatf("v%0d_cksum", i), DW'(pkt_ck), DW'(tbl[i].ck));
      chk($sformatf("v%0d_lines", i), DW'(pkt_lines), DW'(tbl[i].lines));
      chk($sformatf("v%0d_pad", i), DW'(last_pad), DW'(tbl[i].pad));
      chk($sformatf("v%0d_data_hs", i), DW'(hs_cnt - hs0), DW'(tbl[i].hs));
      chk($sformatf("v%0d_rdy_seen", i), DW'(rdy_cnt > r0), DW'(tbl[i].hs > 0));
      chk($sformatf("v%0d_pkts", i), DW'(pkts_done - p0), DW'(1));
    end

    // backpressure in BODY: three stalled cycles, stream must be unchanged
    h = mkhdr(320, 8'h45);
    l0 = lines_total;
    s0 = stall_obs;
    fork
      run_pkt(h, 0);
      begin
        for (int k = 0; k < 500 && lines_total < l0 + 2; k++) @(negedge clk);
        #1 rdy_mode = 2;
        repeat (3) @(negedge clk);
        #1 rdy_mode = 0;
      end
    join
    chk("stall_cycles", DW'(stall_obs - s0), DW'(3));
    chk("stall_lines", DW'(lines_total - l0), DW'(5));

    // asynchronous reset while a BODY line is offered
    h = mkhdr(220, 8'h45);
    add_pkt(h);
    send_hdr(h);
    send_line(pop_line(DB), 1'b0, '0);
    send_line(pop_line(DB), 1'b0, '0);
    rdy_mode = 2;
    dv = 1'b1;
    dd = pop_line(DB);
    dl = 1'b0;
    @(negedge clk);
    chk("pre_rst_val", DW'(ov), DW'(1));
    #1 rst = 1'b1;
    #1;
    chk("async_rst_val", DW'(ov), '0);
    chk("async_rst_hdr_rdy", DW'(hrdy), DW'(1));
    dv = 1'b0;
    while (pay_q.size() > 0) void'(pay_q.pop_front());
    @(negedge clk);
    #2 rst = 1'b0;
    rdy_mode = 0;
    @(posedge clk);
    #1;
    p0 = pkts_done;
    run_pkt(mkhdr(150, 8'h45), 0);
    chk("post_rst_pkts", DW'(pkts_done - p0), DW'(1));

    // randomized back-to-back packets with source gaps and sink stalls
    for (int i = 0; i < 25; i++) begin
      int tl = ($urandom % 5 == 0) ? 20 : int'($urandom_range(21, 1500));
      rh[i] = mkhdr(tl, i % 7 == 3 ? 8'h47 : 8'h45);
      rl[i] = tl - 20;
      add_pkt(rh[i]);
    end
    p0 = pkts_done;
    rdy_mode = 1;
    fork
      for (int i = 0; i < 25; i++) send_hdr(rh[i]);
      for (int j = 0; j < 25; j++) if (rl[j] > 0) send_payload(rl[j], 1);
    join
    wait_out();
    rdy_mode = 0;
    chk("rand_pkts", DW'(pkts_done - p0), DW'(25));
    chk("rand_residue", DW'(exp_q.size() + pay_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ip_tx_hdr_insert_pipe.md
# ip_tx_hdr_insert_pipe

Transmit-side IPv4 framing pipe: accepts an IPv4 header descriptor and a separate payload stream, computes and inserts the header checksum, and emits a single byte-realigned header+payload stream toward the MAC. It is the TX counterpart of the RX IP stream formatter, sitting between the TX protocol engines and the MAC transmit interface. It supports 20-byte headers only (IHL = 5).

## Interface
- DATA_WIDTH, 512: stream width in bits; at least 256.
- DATA_BYTES, DATA_WIDTH/8: bytes per line.
- PADBYTES_WIDTH, $clog2(DATA_BYTES): width of padbytes fields.
- IP_HDR_BYTES, 20: fixed header size (IP_HDR_W = 160 bits).

Ports:
- clk  in  1  clock; the block has one clock.
- rst  in  1  reset, asynchronous, active-high.
- src_ip_format_tx_hdr_val  in  1  header descriptor valid.
- src_ip_format_tx_hdr  in  ip_pkt_hdr (160)  header; checksum field is ignored.
- ip_format_src_tx_hdr_rdy  out  1  header accepted when val & rdy.
- src_ip_format_tx_data_val  in  1  payload line valid.
- src_ip_format_tx_data  in  DATA_WIDTH  payload; byte 0 is at [DATA_WIDTH-1 -: 8].
- src_ip_format_tx_last  in  1  last payload line.
- src_ip_format_tx_padbytes  in  PADBYTES_WIDTH  invalid trailing bytes on the last line.
- ip_format_src_tx_data_rdy  out  1  payload handshake ready.
- ip_format_dst_tx_val  out  1  output line valid.
- ip_format_dst_tx_data  out  DATA_WIDTH  header+payload, MSB-first.
- ip_format_dst_tx_last  out  1  last output line.
- ip_format_dst_tx_padbytes  out  PADBYTES_WIDTH  invalid trailing bytes; meaningful only with last.
- dst_ip_format_tx_rdy  in  1  downstream ready.

## Operation
- **State machine:** IDLE, SUM, FOLD, FIRST, BODY, DRAIN. Reset puts the machine in IDLE.
- **IDLE:** hdr_rdy = 1. On header handshake, register the header and go to SUM.
- **SUM:** one cycle. Form a 20-bit sum of the nine 16-bit header words, with the checksum word treated as zero. Go to FOLD.
- **FOLD:** compute s = sum[15:0] + sum[19:16], then c = ~(s[15:0] + s[16]). Write c into hdr_chksum of the registered header.
  - If tot_len == 20, go to FIRST in header-only mode.
  - Otherwise go to FIRST.
- **FIRST, header-only:** output {hdr, zeros}, last = 1, padbytes = DATA_BYTES-20. No payload is consumed. Go to IDLE on dst_rdy.
- **FIRST, with payload:**
  - dst_val = data_val and data_rdy = dst_rdy (combinational pass-through).
  - Output = {hdr, top DATA_BYTES-20 bytes of the input line}.
  - On handshake, carry_reg <= low 20 bytes of the input line.
- **BODY:** same as FIRST with payload, except hdr is replaced by carry_reg.
- **Last payload line** (applies in FIRST or BODY), with p = input padbytes:
  - If p >= 20: output last = 1, padbytes = p-20. Go to IDLE.
  - If p < 20: output last = 0. Store drain_pad = DATA_BYTES-20+p. Go to DRAIN.
  - A line that is not last moves the machine to BODY.
- **DRAIN:** output {carry_reg, zeros}, last = 1, padbytes = drain_pad, with no payload consumed. Go to IDLE on dst_rdy.
- **Payload length:** packet length is determined solely by src_ip_format_tx_last (plus the tot_len == 20 check). tot_len is not otherwise checked against the beat count.
- **IHL:** must be 5. Any other IHL is forwarded unchanged, but the checksum still covers only 20 bytes.
- **Bytes beyond padding** on output lines are zero.

## Timing
- **Reset values:** state = IDLE, ip_format_dst_tx_val = 0, ip_format_src_tx_data_rdy = 0, ip_format_src_tx_hdr_rdy = 1 (after rst deasserts). carry_reg and the header register are don't-care.
- **Latency:** header handshake at cycle T → SUM at T+1 → FOLD at T+2 → first output line offered at T+3 at the earliest.
- **Throughput:** one line per cycle in FIRST/BODY. One bubble line (DRAIN) is added when p < 20. Per packet there are 3 header overhead cycles, plus 1 cycle in IDLE before the next header is accepted.
- **Handshake rules:**
  - Under dst_rdy = 0, the output data/last/padbytes hold stable while val is high.
  - data_rdy is 0 in IDLE, SUM, FOLD and DRAIN, and in header-only mode.
  - hdr_rdy is 0 outside IDLE.
  - A payload line presented before FIRST is held by the source, never dropped.
- **Reset mid-packet:** the machine returns to IDLE immediately and asynchronously, and dst_val drops. The partial packet is abandoned; its remaining payload beats are the source's responsibility.

## Test plan
- **Known header + two payload lines:**
  - Stimulus: header 4500 0073 0000 4000 4011 xxxx c0a8 0001 c0a8 00c7. Payload is 95 bytes: one full line, then a last line with padbytes = 33.
  - Required response: output checksum field = 0xB861. Line 1 = header + payload bytes 0–43, not last. Line 2 = payload bytes 44–94 (51 bytes), last, padbytes = 13.
- **Header-only packet:** tot_len = 20 → one output line, last = 1, padbytes = 44, data_rdy never asserted, checksum correct.
- **Drain case:** single payload line with padbytes = 4 (60 bytes) →
  - Line 1: header + 44 bytes, not last.
  - Line 2: 16 bytes, last, padbytes = 48.
  - Exactly one payload handshake occurs.
- **Backpressure:** dst_rdy held low for 3 cycles in BODY → output stable throughout, data_rdy = 0, no line lost or duplicated, byte stream identical to the unstalled run.
- **Async reset mid-BODY:** rst pulse asserted without a clock edge → dst_val = 0 immediately. The next header is accepted and its packet is framed correctly.
- **Back-to-back packets:** randomized lengths 20–1500 and random stalls → output byte stream equals a reference model of checksummed headers concatenated with payloads.
